// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU: grants one
// operation at a time, registers its operands, and returns the result to its owner.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_A,
  input  logic [WIDTH-1:0] req0_B,
  input  logic [1:0]       req0_S,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_A,
  input  logic [WIDTH-1:0] req1_B,
  input  logic [1:0]       req1_S,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_C,
  output logic             rsp_Co,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [1:0]       alu_S,
  input  logic [WIDTH-1:0] alu_C,
  input  logic             alu_Co,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic             prio_q, owner_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q, rsp_c_q;
  logic [1:0]       alu_s_q;
  logic             rsp_co_q;

  logic gnt0, gnt1, accept, rsp_hs;

  // prio only breaks ties; a lone requester always wins.
  assign gnt0   = req0_valid && (!req1_valid || !prio_q);
  assign gnt1   = req1_valid && (!req0_valid ||  prio_q);
  assign accept = (state_q == IDLE) && (gnt0 || gnt1);
  assign rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req0_valid || req1_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt0;
        req1_ready = gnt1;
      end
      RESP: begin
        rsp0_valid = !owner_q;
        rsp1_valid =  owner_q;
      end
      default: ;
    endcase
  end

  // NOTE: the datapath registers are reset too, because the ALU ports and the
  // result must read zero while reset is held, not just the control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_s_q  <= '0;
      rsp_c_q  <= '0;
      rsp_co_q <= 1'b0;
    end else begin
      if (accept) begin
        owner_q <= gnt1;
        alu_a_q <= gnt1 ? req1_A : req0_A;
        alu_b_q <= gnt1 ? req1_B : req0_B;
        alu_s_q <= gnt1 ? req1_S : req0_S;
      end
      if (state_q == EXEC) begin
        rsp_c_q  <= alu_C;
        rsp_co_q <= alu_Co;
      end
      if (rsp_hs) prio_q <= ~owner_q;
    end
  end

  assign alu_A  = alu_a_q;
  assign alu_B  = alu_b_q;
  assign alu_S  = alu_s_q;
  assign rsp_C  = rsp_c_q;
  assign rsp_Co = rsp_co_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_A, req0_B, req1_A, req1_B;
  logic [1:0]   req0_S, req1_S;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp_C, alu_A, alu_B, alu_C;
  logic         rsp_Co, alu_Co, busy;
  logic [1:0]   alu_S;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req0_S(req0_S),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_A(req1_A), .req1_B(req1_B), .req1_S(req1_S),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_C(rsp_C), .rsp_Co(rsp_Co),
    .alu_A(alu_A), .alu_B(alu_B), .alu_S(alu_S),
    .alu_C(alu_C), .alu_Co(alu_Co),
    .busy(busy)
  );

  // ALU stub: add for every select value.
  assign {alu_Co, alu_C} = {1'b0, alu_A} + {1'b0, alu_B};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          which;
    logic [31:0] a, b;
    logic [1:0]  s;
    logic [31:0] exp_c;
    logic        exp_co;
    int          hold;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_A = '0; req0_B = '0; req0_S = '0;
    req1_A = '0; req1_B = '0; req1_S = '0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic drive_req(input bit which, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] s);
    if (which) begin
      req1_valid = v; req1_A = a; req1_B = b; req1_S = s;
    end else begin
      req0_valid = v; req0_A = a; req0_B = b; req0_S = s;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    check("reset_busy", busy, 0);
    check("reset_ready", {req0_ready, req1_ready}, 0);
    check("reset_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    check("reset_alu", {alu_A, alu_B, alu_S}, 0);
    check("reset_rsp", {rsp_C, rsp_Co}, 0);
    rst_n = 1;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      req0_valid = 0; req1_valid = 0;
      rsp0_ready = 1; rsp1_ready = 1;
      if (!busy) break;
      tick();
    end
    check("drain_idle", busy, 0);
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  // Single transaction on an idle arbiter with exact cycle timing.
  task automatic run_txn(input vec_t v);
    logic own_valid, oth_valid;
    drive_req(v.which, 1, v.a, v.b, v.s);
    #1;
    check("txn_grant", v.which ? req1_ready : req0_ready, 1);
    check("txn_nogrant", v.which ? req0_ready : req1_ready, 0);
    tick();
    drive_req(v.which, 0, 32'hDEAD_BEEF, 32'h1234_5678, 2'd3);
    check("exec_busy", busy, 1);
    check("exec_alu", {alu_A, alu_B, alu_S}, {v.a, v.b, v.s});
    check("exec_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    tick();
    for (int i = 0; i < v.hold; i++) begin
      own_valid = v.which ? rsp1_valid : rsp0_valid;
      check("hold_valid", own_valid, 1);
      check("hold_rsp", {rsp_C, rsp_Co}, {v.exp_c, v.exp_co});
      tick();
    end
    if (v.which) rsp1_ready = 1; else rsp0_ready = 1;
    #1;
    own_valid = v.which ? rsp1_valid : rsp0_valid;
    oth_valid = v.which ? rsp0_valid : rsp1_valid;
    check("rsp_valid", own_valid, 1);
    check("rsp_other_low", oth_valid, 0);
    check("rsp_result", {rsp_C, rsp_Co}, {v.exp_c, v.exp_co});
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
    check("post_idle", {busy, rsp0_valid, rsp1_valid}, 0);
  endtask

  // Transaction-level reference model state.
  bit          m_act, m_owner, m_prio, winner;
  int          m_age;
  logic [31:0] m_a, m_b;
  logic [1:0]  m_s;
  logic [32:0] m_sum;

  initial begin
    vecs[0] = '{which: 0, a: 32'd123,        b: 32'd456,        s: 2'd2, exp_c: 32'd579,       exp_co: 0, hold: 0};
    vecs[1] = '{which: 1, a: 32'hFFFF_FFFF,  b: 32'd1,          s: 2'd1, exp_c: 32'd0,         exp_co: 1, hold: 0};
    vecs[2] = '{which: 0, a: 32'h8000_0000,  b: 32'h8000_0000,  s: 2'd3, exp_c: 32'd0,         exp_co: 1, hold: 2};
    vecs[3] = '{which: 1, a: 32'd5,          b: 32'd7,          s: 2'd0, exp_c: 32'd12,        exp_co: 0, hold: 1};
    vecs[4] = '{which: 0, a: 32'h7FFF_FFFF,  b: 32'h0000_0001,  s: 2'd2, exp_c: 32'h8000_0000, exp_co: 0, hold: 0};

    idle_inputs();
    rst_n = 1;
    #1;
    do_reset();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Simultaneous requests right after reset: req0 first, req1 3 cycles later, req0 again.
    do_reset();
    drive_req(0, 1, 32'd1, 32'd1, 2'd0);
    drive_req(1, 1, 32'd2, 32'd2, 2'd1);
    rsp0_ready = 1; rsp1_ready = 1;
    #1;
    check("pair_first_grant", {req0_ready, req1_ready}, 2'b10);
    tick();
    check("pair_exec_noready", {req0_ready, req1_ready}, 0);
    tick();
    check("pair_rsp0", {rsp0_valid, rsp1_valid, rsp_C}, {2'b10, 32'd2});
    tick();
    check("pair_second_grant", {req0_ready, req1_ready}, 2'b01);
    tick();
    tick();
    check("pair_rsp1", {rsp0_valid, rsp1_valid, rsp_C}, {2'b01, 32'd4});
    tick();
    check("pair_third_grant", {req0_ready, req1_ready}, 2'b10);
    tick();
    drain();

    // Backpressure on req1 while req0 waits and non-owner rsp0_ready is high.
    do_reset();
    drive_req(1, 1, 32'd40, 32'd2, 2'd1);
    #1;
    check("bp_grant1", req1_ready, 1);
    tick();
    drive_req(1, 0, '0, '0, '0);
    drive_req(0, 1, 32'd9, 32'd9, 2'd0);
    rsp0_ready = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {rsp1_valid, rsp0_valid}, 2'b10);
      check("bp_rsp", {rsp_C, rsp_Co}, {32'd42, 1'b0});
      check("bp_alu", {alu_A, alu_B, alu_S}, {32'd40, 32'd2, 2'd1});
      check("bp_no_grant", {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp1_ready = 1;
    #1;
    check("bp_hs_no_grant", req0_ready, 0);
    tick();
    rsp1_ready = 0;
    check("bp_grant0_after", req0_ready, 1);
    tick();
    drain();

    // Operand change after accept must not reach the result.
    drive_req(0, 1, 32'd10, 32'd20, 2'd2);
    #1;
    check("opchg_grant", req0_ready, 1);
    tick();
    req0_A = 32'd1000;
    req0_B = 32'd5;
    tick();
    check("opchg_result", rsp_C, 32'd30);
    drain();

    // Async reset mid-RESP, between clock edges.
    drive_req(0, 1, 32'd77, 32'd1, 2'd1);
    tick();
    drive_req(0, 0, '0, '0, '0);
    tick();
    check("ar_in_resp", rsp0_valid, 1);
    #2;
    rst_n = 0;
    #1;
    check("ar_immediate", {busy, rsp0_valid, rsp1_valid, rsp_C, rsp_Co, alu_A, alu_B, alu_S}, 0);
    #2;
    rst_n = 1;
    tick();
    check("ar_no_stale", {busy, rsp0_valid, rsp1_valid}, 0);
    drive_req(1, 1, 32'd3, 32'd4, 2'd0);
    #1;
    check("ar_new_grant", req1_ready, 1);
    tick();
    drive_req(1, 0, '0, '0, '0);
    tick();
    check("ar_new_rsp", {rsp1_valid, rsp0_valid, rsp_C}, {2'b10, 32'd7});
    drain();

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_act = 0; m_prio = 0; m_owner = 0; m_age = 0;
    for (int n = 0; n < 600; n++) begin
      drive_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom));
      drive_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 2'($urandom));
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      if (n % 7 == 0) begin
        req0_A = 32'hFFFF_FFFF;
        req1_B = 32'hFFFF_FFFF;
      end
      #2;
      winner = (req0_valid && req1_valid) ? m_prio : req1_valid;
      if (!m_act) begin
        check("rnd_ready", {req0_ready, req1_ready},
              (req0_valid || req1_valid) ? (winner ? 2'b01 : 2'b10) : 2'b00);
        check("rnd_idle", {busy, rsp0_valid, rsp1_valid}, 0);
      end else begin
        check("rnd_busy_ready", {busy, req0_ready, req1_ready}, 3'b100);
        check("rnd_alu", {alu_A, alu_B, alu_S}, {m_a, m_b, m_s});
        if (m_age >= 2) begin
          m_sum = {1'b0, m_a} + {1'b0, m_b};
          check("rnd_rsp_valid", {rsp0_valid, rsp1_valid}, m_owner ? 2'b01 : 2'b10);
          check("rnd_rsp", {rsp_Co, rsp_C}, m_sum);
        end else begin
          check("rnd_exec_valid", {rsp0_valid, rsp1_valid}, 0);
        end
      end
      // Advance the model by one clock edge.
      if (m_act) begin
        if (m_age >= 2 && (m_owner ? rsp1_ready : rsp0_ready)) begin
          m_act  = 0;
          m_prio = ~m_owner;
        end else begin
          m_age++;
        end
      end else if (req0_valid || req1_valid) begin
        m_act   = 1;
        m_age   = 1;
        m_owner = winner;
        m_a     = winner ? req1_A : req0_A;
        m_b     = winner ? req1_B : req0_B;
        m_s     = winner ? req1_S : req0_S;
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
